// File: rtl/branch_pkg.sv
// branch_pkg: 2-bit counter type, counter constants, FSM states and saturating helpers.
// Rev 1.0
`default_nettype none

package branch_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'd0;
  localparam cnt_t CNT_WNT = 2'd1;
  localparam cnt_t CNT_WT  = 2'd2;
  localparam cnt_t CNT_ST  = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_ST) ? CNT_ST : cnt_t'(c + 2'd1);
  endfunction

  function automatic cnt_t sat_dec(input cnt_t c);
    return (c == CNT_SNT) ? CNT_SNT : cnt_t'(c - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_upd_queue.sv
// branch_upd_queue: circular FIFO of {idx, taken} commit updates with per-entry valid/idx for hazard checks.
// Rev 1.0
`default_nettype none

module branch_upd_queue
  import branch_pkg::*;
#(
  parameter int p_idx_bits = 6,
  parameter int p_depth    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enq,
  input  logic [p_idx_bits-1:0]         enq_idx,
  input  logic                          enq_taken,
  input  logic                          deq,
  output logic                          full,
  output logic                          empty,
  output logic [p_idx_bits-1:0]         head_idx,
  output logic                          head_taken,
  output logic [p_depth-1:0]            ent_val,
  output logic [p_depth*p_idx_bits-1:0] ent_idx
);

  localparam int PW = $clog2(p_depth);

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;
  logic [p_idx_bits-1:0] idx_q [p_depth];
  logic                  tk_q  [p_depth];
  logic [p_depth-1:0]    val_q;

  // Enqueue is only offered when not full and dequeue only when non-empty,
  // so head and tail never name the same slot in a cycle where both move.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      val_q <= '0;
    end else begin
      if (enq) begin
        idx_q[tail] <= enq_idx;
        tk_q[tail]  <= enq_taken;
        val_q[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (deq) begin
        val_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full       = (count == (PW+1)'(p_depth));
  assign empty      = (count == '0);
  assign head_idx   = idx_q[head];
  assign head_taken = tk_q[head];
  assign ent_val    = val_q;

  generate
    for (genvar i = 0; i < p_depth; i++) begin : g_ent
      assign ent_idx[i*p_idx_bits +: p_idx_bits] = idx_q[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vc_EnResetReg.sv
// vc_EnResetReg: enabled register with synchronous active-high reset to a fixed value.
// Rev 1.0
`default_nettype none

module vc_EnResetReg #(
  parameter int                 p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [p_nbits-1:0] q,
  input  logic [p_nbits-1:0] d,
  input  logic               en
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= p_reset_value;
    else if (en)
      q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/branch_table_arbiter.sv
// branch_table_arbiter: single-ported 2-bit counter table shared by fetch lookups and queued commit updates.
// Rev 1.0. Optional statistics counters enabled by BRANCH_TABLE_ARB_STATS_EN.
`default_nettype none

module branch_table_arbiter
  import branch_pkg::*;
#(
  parameter int   p_idx_bits    = 6,
  parameter int   p_upd_q_depth = 2,
  parameter cnt_t p_init_cnt    = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lkup_val,
  output logic                  lkup_rdy,
  input  logic [p_idx_bits-1:0] lkup_idx,
  output logic                  pred_val,
  input  logic                  pred_rdy,
  output logic                  pred_taken,
  input  logic                  upd_val,
  output logic                  upd_rdy,
  input  logic [p_idx_bits-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  init_done
`ifdef BRANCH_TABLE_ARB_STATS_EN
  ,
  output logic [31:0]           stat_lkups,
  output logic [31:0]           stat_upds,
  output logic [31:0]           stat_hazard_stalls
`endif
);

  localparam int ENTRIES = 1 << p_idx_bits;

  cnt_t                              tbl [ENTRIES];
  logic [p_idx_bits-1:0]             ptr;
  logic [0:0]                        state_bits;
  state_t                            state;
  logic                              run;
  logic                              q_full;
  logic                              q_empty;
  logic [p_idx_bits-1:0]             q_head_idx;
  logic                              q_head_taken;
  logic [p_upd_q_depth-1:0]          q_val;
  logic [p_upd_q_depth*p_idx_bits-1:0] q_idx;
  logic                              hazard;
  logic                              lookup_fire;
  logic                              drain;
  logic                              enq;
  cnt_t                              upd_cnt;

  assign state = state_t'(state_bits);
  assign run   = (state == ST_RUN);

  vc_EnResetReg #(.p_nbits(1), .p_reset_value(1'(ST_INIT))) state_reg (
    .clk   (clk),
    .reset (reset),
    .q     (state_bits),
    .d     (1'(ST_RUN)),
    .en    (!run && (ptr == '1))
  );

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (!run)
      ptr <= ptr + 1'b1;
  end

  branch_upd_queue #(.p_idx_bits(p_idx_bits), .p_depth(p_upd_q_depth)) upd_q (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq),
    .enq_idx    (upd_idx),
    .enq_taken  (upd_taken),
    .deq        (drain),
    .full       (q_full),
    .empty      (q_empty),
    .head_idx   (q_head_idx),
    .head_taken (q_head_taken),
    .ent_val    (q_val),
    .ent_idx    (q_idx)
  );

  // Only registered queue contents count as a hazard, so an update enqueued
  // this same cycle leaves the lookup seeing the pre-update counter.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < p_upd_q_depth; i++) begin
      if (q_val[i] && (q_idx[i*p_idx_bits +: p_idx_bits] == lkup_idx))
        hazard = 1'b1;
    end
  end

  assign lkup_rdy    = run && (!pred_val || pred_rdy) && !hazard && !q_full;
  assign upd_rdy     = run && !q_full;
  assign enq         = upd_val && upd_rdy;
  assign lookup_fire = lkup_val && lkup_rdy;
  assign drain       = run && (q_full || (!lookup_fire && !q_empty));
  assign upd_cnt     = q_head_taken ? sat_inc(tbl[q_head_idx]) : sat_dec(tbl[q_head_idx]);

  always_ff @(posedge clk) begin
    if (!run)
      tbl[ptr] <= p_init_cnt;
    else if (drain)
      tbl[q_head_idx] <= upd_cnt;
  end

  vc_EnResetReg #(.p_nbits(1), .p_reset_value(1'b0)) pred_val_reg (
    .clk   (clk),
    .reset (reset),
    .q     (pred_val),
    .d     (lookup_fire || (pred_val && !pred_rdy)),
    .en    (1'b1)
  );

  vc_EnResetReg #(.p_nbits(1), .p_reset_value(1'b0)) pred_taken_reg (
    .clk   (clk),
    .reset (reset),
    .q     (pred_taken),
    .d     (tbl[lkup_idx][1]),
    .en    (lookup_fire)
  );

  assign init_done = run;

`ifdef BRANCH_TABLE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lkups         <= '0;
      stat_upds          <= '0;
      stat_hazard_stalls <= '0;
    end else begin
      if (lookup_fire)
        stat_lkups <= stat_lkups + 32'd1;
      if (drain)
        stat_upds <= stat_upds + 32'd1;
      if (run && lkup_val && hazard)
        stat_hazard_stalls <= stat_hazard_stalls + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/branch_table_arbiter.md
Name: branch_table_arbiter

Overview:
- Owns and sequences a single-ported table of 2-bit saturating branch counters.
- Arbitrates between two requesters: fetch-side prediction lookups and commit-side updates.
- Commit-side updates are buffered in a small queue so they never stall commit.
- Runs an initialization sweep after reset. Sits between the fetch stage and commit in the branch-predictor datapath.

Parameters:
- p_idx_bits, 6, table index width; table has 2**p_idx_bits entries.
- p_upd_q_depth, 2, update queue entries (power of two, >=2).
- p_init_cnt, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- lkup_val  in  1  lookup request valid
- lkup_rdy  out  1  lookup request accepted when val&rdy
- lkup_idx  in  p_idx_bits  lookup table index
- pred_val  out  1  prediction response valid
- pred_rdy  in  1  prediction consumer ready
- pred_taken  out  1  predicted direction (counter MSB)
- upd_val  in  1  update request valid
- upd_rdy  out  1  update accepted when val&rdy
- upd_idx  in  p_idx_bits  update table index
- upd_taken  in  1  resolved branch direction
- init_done  out  1  high once init sweep complete

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: lkup_rdy=0, upd_rdy=0, pred_val=0, pred_taken=0, init_done=0. Queue is emptied; FSM enters INIT with sweep pointer 0. Table contents are not reset directly; the sweep overwrites them.
- FSM states: INIT and RUN.
- INIT:
  - Writes p_init_cnt to entry ptr each cycle; ptr increments.
  - After the last entry (ptr == 2**p_idx_bits-1), go to RUN.
  - lkup_rdy=upd_rdy=0 throughout.
  - Sweep takes exactly 2**p_idx_bits cycles after reset deasserts.
- RUN: init_done=1. Exactly one table access per cycle (a read or a read-modify-write).
- upd_rdy = queue not full; it is combinational from registered queue count.
- lkup_rdy = RUN & (!pred_val | pred_rdy) & !hazard & !q_full.
  - hazard = lkup_idx matches any valid queue entry's idx.
- Port slot priority, highest first:
  - (1) queue full -> drain head;
  - (2) lkup_val & lkup_rdy -> lookup;
  - (3) queue non-empty -> drain head;
  - (4) idle.
- Hazard on a valid lookup always leaves the slot to (3), so the stall is bounded by the queue depth.
- Drain: cnt' = taken ? sat_inc(cnt) : sat_dec(cnt), saturating at 3 and 0; result written the same cycle; head pops.
- Lookup latency: 1 cycle. pred_taken = table[idx][1] registered; pred_val set the next cycle and held until pred_val&pred_rdy.
- Simultaneous upd enqueue and lookup of the same idx: the lookup sees the pre-update value (hazard checks registered queue contents only).
- Simultaneous enqueue and drain in one cycle: count unchanged. Enqueue when full is impossible (upd_rdy=0).
- Reset asserted mid-RUN: queued updates and any pending prediction are discarded; sweep restarts at 0.

Optional Feature:
- BRANCH_TABLE_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_lkups[31:0] (accepted lookups), stat_upds[31:0] (drained updates) and stat_hazard_stalls[31:0] (cycles with lkup_val & hazard in RUN).
  - All three reset to 0 and wrap at 2**32.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - typedef cnt_t (2-bit counter);
  - constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3;
  - state enum {ST_INIT, ST_RUN};
  - functions sat_inc and sat_dec.
- Sub-module branch_upd_queue: circular FIFO of {idx, taken}. Exposes full, empty and a per-entry valid/idx vector for the hazard compare.
- The registered pred_taken/pred_val and the FSM state use vc_EnResetReg.

Test Plan (p_idx_bits=4, depth 2):
- Init: deassert reset -> init_done rises on cycle 16, rdy=0 before that; lookup idx 5 -> pred_val next cycle, pred_taken=0.
- Saturation:
  - three updates idx 3 taken, then lookup 3 -> pred_taken=1 (counter 3);
  - one more taken, then one not-taken -> counter 2, still taken;
  - then two not-taken -> 0; a third not-taken stays 0.
- Hazard: enqueue upd idx 7 taken, next cycle lookup 7 -> lkup_rdy=0 until the drain, then the lookup is accepted and sees counter 2 (pred_taken=1).
- Queue full: two back-to-back updates with lkup_val held -> upd_rdy=0 and lkup_rdy=0 while full; drain goes first, then the lookup.
- Backpressure: pred_rdy=0 with a pending pred -> lkup_rdy=0, pred_taken held stable; pred_rdy=1 -> pops and accepts a new lookup in the same cycle.
- Reset mid-RUN with 2 queued updates -> queue empty, pred_val=0, init_done=0 for 16 cycles; later lookup of a previously trained idx returns weakly not-taken.
